// File: rtl/ped_pkg.sv
// Shared types and counter widths for the pedestrian request front end.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCK    = 2'd2
  } ped_state_e;

  localparam int DEB_W   = 8;
  localparam int LOCK_W  = 8;
  localparam int BLINK_W = 8;
  localparam int TMO_W   = 16;

endpackage

// File: rtl/ped_debounce.sv
// Button synchroniser, tick-paced debouncer and press event generator.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEB_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_n,
  output logic btn_level,
  output logic press_evt
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             btn_s;
  logic [DEB_W-1:0] deb_cnt;

  // Flops come out of reset at the released (high) level so no false press is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_s = ~sync_q2;

  // press_evt is raised in the same edge as the debounced rise so the FSM reacts one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (btn_s == btn_level) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_cnt == DEB_LAST) begin
          btn_level <= btn_s;
          deb_cnt   <= '0;
          press_evt <= btn_s;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ped_request.sv
// Pedestrian request front end: debounced button, request latch, lockout and wait lamp.
// Optional request expiry is built when PED_REQ_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no request, waiting for a press
// PENDING | request latched, ped_req high, wait lamp blinking
// LOCK    | crossing granted, presses ignored for LOCK_TICKS ticks
module ped_request
  import ped_pkg::*;
#(
  parameter int DEB_TICKS     = 20,
  parameter int LOCK_TICKS    = 50,
  parameter int BLINK_TICKS   = 5,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_n,
  input  logic       grant,
  output logic       ped_req,
  output logic       wait_led,
  output logic       btn_level,
  output logic [7:0] press_cnt,
  output logic       timeout
);

  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_TICKS - 1);

  ped_state_e         state_q;
  ped_state_e         state_d;
  logic               press_evt;
  logic               press_acc;
  logic               pend_entry;
  logic               pend_expire;
  logic               lock_done;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               wait_q;

  ped_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_n     (btn_n),
    .btn_level (btn_level),
    .press_evt (press_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign lock_done = tick && (lock_cnt == LOCK_LAST);

  // grant is checked ahead of expiry so a coincident grant always wins.
  always_comb begin
    state_d   = state_q;
    press_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_evt) begin
          state_d   = PENDING;
          press_acc = 1'b1;
        end
      end
      PENDING: begin
        if (grant)            state_d = LOCK;
        else if (pend_expire) state_d = IDLE;
      end
      LOCK: begin
        if (lock_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_entry = (state_q != PENDING) && (state_d == PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt <= '0;
    end else if (press_acc && (press_cnt != 8'hFF)) begin
      press_cnt <= press_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if ((state_q == PENDING) && (state_d == LOCK)) begin
      lock_cnt <= '0;
    end else if ((state_q == LOCK) && tick) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Lamp follows the next state so it drops in the same edge as ped_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= 1'b0;
      blink_cnt <= '0;
    end else if (state_d != PENDING) begin
      wait_q    <= 1'b0;
      blink_cnt <= '0;
    end else if (pend_entry) begin
      wait_q    <= 1'b1;
      blink_cnt <= '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        wait_q    <= ~wait_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign ped_req  = (state_q == PENDING);
  assign wait_led = wait_q;

`ifdef PED_REQ_TIMEOUT_EN
  logic [TMO_W-1:0] pend_cnt;
  logic             timeout_q;

  assign pend_expire = tick && (pend_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == PENDING) && !grant && pend_expire;
      if (pend_entry)                        pend_cnt <= '0;
      else if ((state_q == PENDING) && tick) pend_cnt <= pend_cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_tmo;

  assign pend_expire = 1'b0;
  assign timeout     = 1'b0;
  assign unused_tmo  = ^TMO_LAST;
`endif

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed scenarios plus random button/grant traffic against a tick-level model.
module tb_ped_request;

  localparam int DEB   = 4;
  localparam int LOCKT = 3;
  localparam int BLINK = 2;
  localparam int TMO   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       btn_n = 1'b1;
  logic       grant = 1'b0;
  logic       ped_req;
  logic       wait_led;
  logic       btn_level;
  logic [7:0] press_cnt;
  logic       timeout;

  ped_request #(
    .DEB_TICKS     (DEB),
    .LOCK_TICKS    (LOCKT),
    .BLINK_TICKS   (BLINK),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_n     (btn_n),
    .grant     (grant),
    .ped_req   (ped_req),
    .wait_led  (wait_led),
    .btn_level (btn_level),
    .press_cnt (press_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 pending, 2 lockout
  bit m_sync1, m_sync2, m_level, m_evt, m_tmo;
  int m_run, m_mode, m_cnt, m_pticks, m_lock_left;

  task automatic model_reset();
    m_sync1 = 1; m_sync2 = 1; m_level = 0; m_evt = 0; m_tmo = 0;
    m_run = 0; m_mode = 0; m_cnt = 0; m_pticks = 0; m_lock_left = 0;
  endtask

  task automatic model_step();
    bit bs, evt_old, nevt;
    bs      = !m_sync2;
    evt_old = m_evt;
    nevt    = 0;
    if (bs == m_level) m_run = 0;
    else if (tick) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = bs;
        m_run   = 0;
        nevt    = bs;
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = btn_n;
    m_evt   = nevt;
    m_tmo   = 0;
    case (m_mode)
      0: if (evt_old) begin
           m_mode = 1; m_pticks = 0;
           if (m_cnt < 255) m_cnt++;
         end
      1: if (grant) begin
           m_mode = 2; m_lock_left = LOCKT;
         end else if (tick) begin
           m_pticks++;
`ifdef PED_REQ_TIMEOUT_EN
           if (m_pticks == TMO) begin m_mode = 0; m_tmo = 1; end
`endif
         end
      default: if (tick) begin
           m_lock_left--;
           if (m_lock_left == 0) m_mode = 0;
         end
    endcase
  endtask

  task automatic compare_all();
    check_eq("ped_req", ped_req, m_mode == 1);
    check_eq("wait_led", wait_led, (m_mode == 1) && ((m_pticks / BLINK) % 2 == 0));
    check_eq("btn_level", btn_level, m_level);
    check_eq("press_cnt", press_cnt, m_cnt);
    check_eq("timeout", timeout, m_tmo);
  endtask

  int tick_per = 10;
  int tick_ph  = 0;

  task automatic set_tick_per(input int p);
    tick_per = p;
    tick_ph  = 0;
  endtask

  // Called just after a falling edge; inputs other than tick are set by the caller.
  task automatic step();
    tick    = (tick_ph == 0);
    tick_ph = (tick_ph + 1) % tick_per;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press_until_pending();
    int n;
    btn_n = 0;
    n = 0;
    while (m_mode != 1 && n < 500) begin step(); n++; end
    check_eq("press_bound", m_mode, 1);
  endtask

  task automatic release_until_idle();
    int n;
    btn_n = 1;
    n = 0;
    while ((m_mode != 0 || m_level != 0) && n < 500) begin
      grant = (m_mode == 1);
      step();
      n++;
    end
    grant = 0;
    check_eq("release_bound", m_mode + m_level, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, ped_req, 0);
    check_eq({tag, "_led"}, wait_led, 0);
    check_eq({tag, "_lvl"}, btn_level, 0);
    check_eq({tag, "_cnt"}, press_cnt, 0);
    check_eq({tag, "_tmo"}, timeout, 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #1 check_all_zero("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // clean press
    set_tick_per(10);
    btn_n = 0;
    repeat (100) step();
    check_eq("clean_cnt", press_cnt, 1);
    check_eq("clean_req", ped_req, 1);
    grant = 1; step(); grant = 0;
    check_eq("grant_req", ped_req, 0);
    check_eq("grant_led", wait_led, 0);
    release_until_idle();

    // bounce: 15-clk toggles are shorter than the debounce window
    for (int k = 0; k < 4; k++) begin
      btn_n = ~btn_n;
      repeat (15) step();
      check_eq("bounce_lvl", btn_level, 0);
    end
    btn_n = 0;
    repeat (80) step();
    check_eq("bounce_cnt", press_cnt, 2);
    release_until_idle();

    // lockout: the debounced press lands inside LOCK and is ignored
    set_tick_per(4);
    press_until_pending();
    btn_n = 1;
    for (int n = 0; n < 200 && m_level != 0; n++) step();
    btn_n = 0;
    repeat (8) step();
    grant = 1; step(); grant = 0;
    repeat (14) step();
    check_eq("lock_ignore", press_cnt, 3);
    release_until_idle();
    press_until_pending();
    check_eq("relock_cnt", press_cnt, 4);
    check_eq("relock_req", ped_req, 1);
    repeat (20) step();
    release_until_idle();

`ifdef PED_REQ_TIMEOUT_EN
    // expiry without grant
    press_until_pending();
    for (int n = 0; n < 300 && m_mode == 1; n++) step();
    check_eq("tmo_pulse", timeout, 1);
    check_eq("tmo_req", ped_req, 0);
    step();
    check_eq("tmo_once", timeout, 0);
    release_until_idle();
    // grant coincident with expiry
    press_until_pending();
    btn_n = 1;
    for (int n = 0; n < 300 && m_mode == 1; n++) begin
      grant = (tick_ph == 0) && (m_pticks == TMO - 1);
      step();
    end
    grant = 0;
    check_eq("tmo_grant_pulse", timeout, 0);
    check_eq("tmo_grant_mode", m_mode, 2);
    release_until_idle();
`endif

    // reset mid-request
    press_until_pending();
    #2 rst_n = 0;
    #1 check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    repeat (3) step();
    rst_n = 1;
    step();
    check_eq("midrst_lvl", btn_level, 0);
    repeat (40) step();
    release_until_idle();

    // random traffic
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      set_tick_per($urandom_range(1, 6));
      btn_n = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) btn_n = ~btn_n;
        grant = ($urandom_range(0, 24) == 0);
        step();
      end
      grant = 0;
    end

    // press counter saturation
    release_until_idle();
    set_tick_per(1);
    for (int p = 0; p < 260; p++) begin
      btn_n = 0;
      repeat (10) step();
      grant = 1; step(); grant = 0;
      btn_n = 1;
      repeat (12) step();
    end
    check_eq("sat_cnt", press_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
